addr_bus_arbiter: RTL and testbench



---
 rtl/addr_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_addr_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_bus_arbiter.sv
// Round-robin owner arbiter for the 16-bit address-bus mux: drives in_selector with a one-cycle turnaround and hold limit.
// Optional vector-address owner (selector 13, bus 0xFFFF) is enabled by defining ABUS_ARB_VECTOR_EN.

module addr_bus_arbiter #(
    parameter int NUM_REQ    = 7,
    parameter int MAX_HOLD   = 8,
    parameter int HOLD_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ABUS_ARB_VECTOR_EN
    input  logic               vec_req,
    output logic               vec_grant,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [3:0]         in_selector,
    output logic [2:0]         owner_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_TURN   = 2'd2,
        ST_VGRANT = 2'd3
    } state_t;

    localparam logic [3:0]            SEL_NONE  = 4'd0;
    localparam logic [3:0]            SEL_VEC   = 4'd13;
    localparam logic [2:0]            VEC_OWNER = 3'd7;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_SAT  = HOLD_WIDTH'(MAX_HOLD);

    state_t                  state_q;
    logic [NUM_REQ-1:0]      grant_q;
    logic [3:0]              sel_q;
    logic [2:0]              owner_q;
    logic                    busy_q;
    logic [HOLD_WIDTH-1:0]   hold_q;
    logic [HOLD_WIDTH-1:0]   hold_d;
    logic [2:0]              rr_q;
`ifdef ABUS_ARB_VECTOR_EN
    logic                    vec_q;
`endif

    logic [2:0]              win_s;
    logic [3:0]              cand_s;
    logic                    any_s;
    logic                    own_s;
    logic                    other_s;
    logic                    release_s;

    // Requester index to address-bus mux code; codes 3..6 belong to other bus sources.
    function automatic logic [3:0] sel_code(input logic [2:0] idx);
        logic [3:0] code;
        case (idx)
            3'd0:    code = 4'd1;
            3'd1:    code = 4'd2;
            3'd2:    code = 4'd7;
            3'd3:    code = 4'd8;
            3'd4:    code = 4'd9;
            3'd5:    code = 4'd10;
            3'd6:    code = 4'd11;
            default: code = SEL_NONE;
        endcase
        return code;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        logic [2:0] p;
        if (idx == 3'(NUM_REQ - 1)) begin
            p = 3'd0;
        end else begin
            p = idx + 3'd1;
        end
        return p;
    endfunction

    // Round-robin search from rr_q; descending loop so the nearest requester wins.
    always_comb begin
        win_s  = 3'd0;
        cand_s = 4'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = {1'b0, rr_q} + 4'(k);
            if (cand_s >= 4'(NUM_REQ)) begin
                cand_s = cand_s - 4'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            win_s = req[cand_s[2:0]] ? cand_s[2:0] : win_s;
        end
    end

    assign any_s   = |req;
    assign own_s   = |(req & grant_q);
    assign other_s = |(req & ~grant_q);
    assign hold_d  = (hold_q < HOLD_SAT) ? hold_q + HOLD_WIDTH'(1) : hold_q;
    // >= rather than == so a requester arriving after saturation still forces release.
    assign release_s = !own_s || ((hold_q >= HOLD_LAST) && other_s);

    // Arbiter FSM with registered outputs; every path starts from the all-zero TURN/IDLE output set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= SEL_NONE;
            owner_q <= 3'd0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            rr_q    <= 3'd0;
`ifdef ABUS_ARB_VECTOR_EN
            vec_q   <= 1'b0;
`endif
        end else begin
            grant_q <= '0;
            sel_q   <= SEL_NONE;
            owner_q <= 3'd0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
`ifdef ABUS_ARB_VECTOR_EN
            vec_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE, ST_TURN: begin
`ifdef ABUS_ARB_VECTOR_EN
                    if (vec_req) begin
                        state_q <= ST_VGRANT;
                        sel_q   <= SEL_VEC;
                        owner_q <= VEC_OWNER;
                        busy_q  <= 1'b1;
                        vec_q   <= 1'b1;
                    end else
`endif
                    if (any_s) begin
                        state_q <= ST_GRANT;
                        grant_q <= onehot(win_s);
                        sel_q   <= sel_code(win_s);
                        owner_q <= win_s;
                        busy_q  <= 1'b1;
                        rr_q    <= next_ptr(win_s);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        state_q <= ST_TURN;
                    end else begin
                        state_q <= ST_GRANT;
                        grant_q <= grant_q;
                        sel_q   <= sel_q;
                        owner_q <= owner_q;
                        busy_q  <= 1'b1;
                        hold_q  <= hold_d;
                    end
                end
`ifdef ABUS_ARB_VECTOR_EN
                ST_VGRANT: begin
                    if (!vec_req) begin
                        state_q <= ST_TURN;
                    end else begin
                        state_q <= ST_VGRANT;
                        sel_q   <= SEL_VEC;
                        owner_q <= VEC_OWNER;
                        busy_q  <= 1'b1;
                        vec_q   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign in_selector = sel_q;
    assign owner_id    = owner_q;
    assign busy        = busy_q;
`ifdef ABUS_ARB_VECTOR_EN
    assign vec_grant   = vec_q;
`endif

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Self-checking bench for addr_bus_arbiter: owner-level behavioural model compared every cycle, plus literal checks.
// Vector-owner checks are compiled in when ABUS_ARB_VECTOR_EN is defined.

module tb_addr_bus_arbiter;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] req   = 7'd0;
    logic       vec_req = 1'b0;
    logic [6:0] grant;
    logic [3:0] in_selector;
    logic [2:0] owner_id;
    logic       busy;
`ifdef ABUS_ARB_VECTOR_EN
    logic       vec_grant;
`endif

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // phase: 0 idle, 1 owned by a requester, 2 turnaround, 3 vector owner
    typedef struct packed {
        int phase;
        int owner;
        int ptr;
        int held;
    } mstate_t;

    mstate_t m = '0;
    int sel_tab [7] = '{1, 2, 7, 8, 9, 10, 11};

    addr_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
`ifdef ABUS_ARB_VECTOR_EN
        .vec_req     (vec_req),
        .vec_grant   (vec_grant),
`endif
        .req         (req),
        .grant       (grant),
        .in_selector (in_selector),
        .owner_id    (owner_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [6:0] r, input int start);
        for (int k = 0; k < 7; k++) begin
            int i;
            i = (start + k) % 7;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic rst,
                                           input logic [6:0] r, input logic v);
        mstate_t    n;
        logic [6:0] others;
        int         w;
        n = s;
        if (rst) begin
            n = '0;
        end else if (s.phase == 1) begin
            others          = r;
            others[s.owner] = 1'b0;
            if (!r[s.owner] || (s.held >= 8 && others != 7'd0)) n.phase = 2;
            else n.held = s.held + 1;
        end else if (s.phase == 3) begin
            if (!v) n.phase = 2;
        end else begin
            w = rr_pick(r, s.ptr);
            if (v) begin
                n.phase = 3;
            end else if (w < 0) begin
                n.phase = 0;
            end else begin
                n.phase = 1;
                n.owner = w;
                n.ptr   = (w + 1) % 7;
                n.held  = 1;
            end
        end
        return n;
    endfunction

    task automatic compare_model(input mstate_t s);
        logic [6:0] g;
        int sel, oid, bsy;
        g   = 7'd0;
        sel = 0;
        oid = 0;
        bsy = 0;
        if (s.phase == 1) begin
            g[s.owner] = 1'b1;
            sel = sel_tab[s.owner];
            oid = s.owner;
            bsy = 1;
        end else if (s.phase == 3) begin
            sel = 13;
            oid = 7;
            bsy = 1;
        end
        check("model_grant", 32'(grant), 32'(g));
        check("model_sel",   32'(in_selector), sel);
        check("model_owner", 32'(owner_id), oid);
        check("model_busy",  32'(busy), bsy);
`ifdef ABUS_ARB_VECTOR_EN
        check("model_vec_grant", 32'(vec_grant), (s.phase == 3) ? 1 : 0);
`endif
    endtask

    always @(posedge clk) m <= model_step(m, reset, req, vec_req);

    always @(negedge clk) if (check_en) compare_model(m);

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [6:0] g, input logic [3:0] sel, input logic b);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_sel"},   32'(in_selector), 32'(sel));
        check({tag, "_busy"},  32'(busy), 32'(b));
    endtask

    logic [3:0] seq [28];
    int idx_tab [9] = '{0, 7, 8, 9, 16, 17, 18, 26, 27};
    int exp_tab [9] = '{1, 1, 0, 7, 7, 0, 11, 0, 1};

    initial begin
        // reset state
        tick(2);
        check_en = 1'b1;
        expect_out("reset", 7'b0000000, 4'd0, 1'b0);
        check("reset_owner", 32'(owner_id), 32'd0);
        reset = 1'b0;

        // single requester pc, then drop
        req = 7'b0000001;
        tick(1);
        expect_out("pc_grant", 7'b0000001, 4'd1, 1'b1);
        req = 7'b0000000;
        tick(1);
        expect_out("pc_turn", 7'b0000000, 4'd0, 1'b0);
        tick(1);
        expect_out("pc_idle", 7'b0000000, 4'd0, 1'b0);

        // three contenders held: forced release every 8 cycles with a 1-cycle gap
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        req = 7'b1000101;
        for (int i = 0; i < 28; i++) begin
            tick(1);
            seq[i] = in_selector;
        end
        for (int i = 0; i < 9; i++) begin
            check($sformatf("rr_seq[%0d]", idx_tab[i]), 32'(seq[idx_tab[i]]), exp_tab[i]);
        end
        req = 7'b0000000;
        tick(2);

        // sole requester fetch keeps the bus past the hold limit
        req = 7'b0010000;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            expect_out("sole_fetch", 7'b0010000, 4'd9, 1'b1);
        end
        req = 7'b0000000;
        tick(2);

        // decode drops on its last allowed cycle while sp is pending: one TURN only
        req = 7'b0100010;
        tick(1);
        expect_out("decode_grant", 7'b0100000, 4'd10, 1'b1);
        tick(7);
        expect_out("decode_last", 7'b0100000, 4'd10, 1'b1);
        req = 7'b0000010;
        tick(1);
        expect_out("drop_turn", 7'b0000000, 4'd0, 1'b0);
        tick(1);
        expect_out("sp_grant", 7'b0000010, 4'd2, 1'b1);
        req = 7'b0000000;
        tick(2);

        // reset mid-grant of imm, then rr_ptr restarts at 0
        req = 7'b0001000;
        tick(1);
        expect_out("imm_grant", 7'b0001000, 4'd8, 1'b1);
        reset = 1'b1;
        req = 7'b0010000;
        tick(1);
        expect_out("mid_reset", 7'b0000000, 4'd0, 1'b0);
        check("mid_reset_owner", 32'(owner_id), 32'd0);
        reset = 1'b0;
        tick(1);
        expect_out("post_reset_fetch", 7'b0010000, 4'd9, 1'b1);
        check("post_reset_owner", 32'(owner_id), 32'd4);
        req = 7'b0000000;
        tick(2);

        // two contenders alternate under the hold limit (model-checked)
        req = 7'b0001001;
        tick(40);
        req = 7'b0000000;
        tick(2);

        // one-cycle request pulse in IDLE
        req = 7'b0000100;
        tick(1);
        req = 7'b0000000;
        expect_out("pulse_grant", 7'b0000100, 4'd7, 1'b1);
        tick(1);
        expect_out("pulse_turn", 7'b0000000, 4'd0, 1'b0);
        tick(2);

`ifdef ABUS_ARB_VECTOR_EN
        // vector request never preempts a running grant
        req = 7'b1000000;
        tick(1);
        expect_out("alu_grant", 7'b1000000, 4'd11, 1'b1);
        vec_req = 1'b1;
        tick(3);
        expect_out("alu_keeps", 7'b1000000, 4'd11, 1'b1);
        req = 7'b0000000;
        tick(1);
        expect_out("vec_turn", 7'b0000000, 4'd0, 1'b0);
        tick(1);
        expect_out("vec_own", 7'b0000000, 4'd13, 1'b1);
        check("vec_grant_hi", 32'(vec_grant), 32'd1);
        check("vec_owner", 32'(owner_id), 32'd7);
        tick(12);
        check("vec_no_limit", 32'(in_selector), 32'd13);
        vec_req = 1'b0;
        tick(1);
        check("vec_release", 32'(vec_grant), 32'd0);
        tick(2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
